seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (even, >=8).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  5  operation code (REQ-012).
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result/cmp valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports result  output  WIDTH  and cmp  output  1  (branch condition true).

Function
REQ-012 op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU, 16 MUL, 17 MULH, 18 MULHU, 19 DIV, 20 DIVU, 21 REM, 22 REMU; 23-31 illegal.
REQ-013 States SHALL be IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-014 Request accepted when in_valid && in_ready; a, b, op captured that edge; later input changes ignored.
REQ-015 Ops 0-15 and illegal: IDLE -> DONE, out_valid high exactly 1 cycle after accept.
REQ-016 Ops 16-22: IDLE -> CALC, iterative 1 bit/cycle for WIDTH cycles, then DONE; out_valid high WIDTH+1 cycles after accept.
REQ-017 DONE: out_valid = 1, result/cmp held stable until out_valid && out_ready, then -> IDLE next edge; no new request accepted in the same cycle.
REQ-018 SLT/SLTU result = {WIDTH-1 zeros, flag}; SRA sign-fills; shifts by b[SHW-1:0] only.
REQ-019 Branch ops: result = a - b (mod 2^WIDTH); cmp per signed (BLT/BGE) or unsigned (BLTU/BGEU) or equality compare; cmp = 0 for all non-branch ops.
REQ-020 MUL = low WIDTH bits of product; MULH = high WIDTH bits, signed x signed; MULHU = high WIDTH bits, unsigned x unsigned.
REQ-021 Divide by zero: DIV/DIVU result all-ones, REM/REMU result = a.
REQ-022 Signed overflow (a = most-negative, b = -1): DIV result = a, REM result = 0.
REQ-023 DIV/REM signs: quotient truncates toward zero; remainder takes sign of a.
REQ-024 Illegal op: result = 0, cmp = 0.
REQ-025 All arithmetic wraps modulo 2^WIDTH; no overflow flags.

Reset
REQ-026 rst high SHALL force state IDLE, out_valid = 0, result = 0, cmp = 0, in_ready = 1 the following cycle.
REQ-027 rst mid-CALC or mid-DONE SHALL discard the pending operation; no out_valid is produced for it.
REQ-028 in_valid during rst SHALL be ignored.

Verification
REQ-029 ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid cycle+1, result=0x00000000, cmp=0.
REQ-030 BLTU a=1, b=0xFFFFFFFF -> cmp=1; BLT same operands -> cmp=0; result=0x00000002 both.
REQ-031 MULH a=0x80000000, b=0x80000000 -> out_valid exactly 33 cycles after accept, result=0x40000000; MUL same -> 0x00000000.
REQ-032 DIV a=7, b=0 -> 0xFFFFFFFF; REM a=-7, b=2 -> 0xFFFFFFFF (-1); DIV a=0x80000000, b=-1 -> 0x80000000.
REQ-033 SRA a=0x80000000, b=0x24 (amount 4) with out_ready=0 for 5 cycles -> result 0xF8000000 held, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-034 Start DIVU, assert rst at cycle 10 -> out_valid never rises for it, in_ready=1 cycle after rst; next ADD 2+3 -> 5.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle ALU/branch ops and iterative
// 1-bit-per-cycle multiply/divide, valid/ready handshake on both sides.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cmp
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,
                         OP_OR   = 5'd3,  OP_XOR  = 5'd4,  OP_SLL  = 5'd5,
                         OP_SRL  = 5'd6,  OP_SRA  = 5'd7,  OP_SLT  = 5'd8,
                         OP_SLTU = 5'd9,  OP_BEQ  = 5'd10, OP_BNE  = 5'd11,
                         OP_BLT  = 5'd12, OP_BGE  = 5'd13, OP_BLTU = 5'd14,
                         OP_BGEU = 5'd15, OP_MUL  = 5'd16, OP_MULH = 5'd17,
                         OP_MULHU= 5'd18, OP_DIV  = 5'd19, OP_DIVU = 5'd20,
                         OP_REM  = 5'd21, OP_REMU = 5'd22;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;        // original dividend, for REM by zero
  logic [WIDTH:0]     acc_q, acc_d;    // product high half / partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;      // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand / divisor magnitude
  logic               neg_q, neg_d;    // negate final magnitude
  logic               bz_q, bz_d;      // divisor was zero
  logic               isdiv_q, isdiv_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cmp_q, cmp_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cmp       = cmp_q;

  // Single-cycle ALU and branch compare, evaluated on the live inputs at accept
  logic [WIDTH-1:0] alu_res, diff;
  logic             alu_cmp;
  logic [SHW-1:0]   sh;
  always_comb begin
    alu_res = '0;
    alu_cmp = 1'b0;
    diff    = a - b;
    sh      = b[SHW-1:0];
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $signed(a) >>> sh;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_BEQ:  begin alu_res = diff; alu_cmp = (a == b); end
      OP_BNE:  begin alu_res = diff; alu_cmp = (a != b); end
      OP_BLT:  begin alu_res = diff; alu_cmp = ($signed(a) <  $signed(b)); end
      OP_BGE:  begin alu_res = diff; alu_cmp = ($signed(a) >= $signed(b)); end
      OP_BLTU: begin alu_res = diff; alu_cmp = (a <  b); end
      OP_BGEU: begin alu_res = diff; alu_cmp = (a >= b); end
      default: ;
    endcase
  end

  // Operand setup for mul/div: signed ops work on magnitudes, sign fixed at the end
  logic             is_multi, sgn_op, sa, sb;
  logic [WIDTH-1:0] ma, mb;
  always_comb begin
    is_multi = (op >= OP_MUL) && (op <= OP_REMU);
    sgn_op   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa       = sgn_op && a[WIDTH-1];
    sb       = sgn_op && b[WIDTH-1];
    ma       = sa ? -a : a;
    mb       = sb ? -b : b;
  end

  // One iteration of shift-add multiply or restoring divide
  logic [WIDTH:0]     mul_sum, rem_sh, div_sub;
  logic [2*WIDTH:0]   mul_full, mul_sh;
  logic               div_ge;
  logic [WIDTH:0]     acc_n;
  logic [WIDTH-1:0]   lo_n;
  always_comb begin
    mul_sum  = acc_q + {1'b0, opnd_q};
    mul_full = lo_q[0] ? {mul_sum, lo_q} : {acc_q, lo_q};
    mul_sh   = mul_full >> 1;
    rem_sh   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, opnd_q});
    div_sub  = rem_sh - {1'b0, opnd_q};
    if (isdiv_q) begin
      acc_n = div_ge ? div_sub : rem_sh;
      lo_n  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      acc_n = mul_sh[2*WIDTH:WIDTH];
      lo_n  = mul_sh[WIDTH-1:0];
    end
  end

  // Final result from the last iteration's output, with sign and corner fixes
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fin_res;
  always_comb begin
    prod    = {acc_n[WIDTH-1:0], lo_n};
    prod_s  = neg_q ? -prod : prod;
    quo_s   = neg_q ? -lo_n : lo_n;
    rem_s   = neg_q ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    fin_res = '0;
    case (op_q)
      OP_MUL:            fin_res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHU: fin_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:   fin_res = bz_q ? '1 : quo_s;
      OP_REM, OP_REMU:   fin_res = bz_q ? a_q : rem_s;
      default: ;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/CALC/DONE controller
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    neg_d       = neg_q;
    bz_d        = bz_q;
    isdiv_d     = isdiv_q;
    result_d    = result_q;
    cmp_d       = cmp_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          op_d       = op;
          a_d        = a;
          if (is_multi) begin
            state_d = S_CALC;
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = ma;
            opnd_d  = mb;
            neg_d   = (op == OP_REM) ? sa : (sa ^ sb);
            bz_d    = (b == '0);
            isdiv_d = (op >= OP_DIV);
          end else begin
            state_d     = S_DONE;
            result_d    = alu_res;
            cmp_d       = alu_cmp;
            out_valid_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          result_d    = fin_res;
          cmp_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State register; reset drops any pending operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      bz_q        <= 1'b0;
      isdiv_q     <= 1'b0;
      result_q    <= '0;
      cmp_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      neg_q       <= neg_d;
      bz_q        <= bz_d;
      isdiv_q     <= isdiv_d;
      result_q    <= result_d;
      cmp_q       <= cmp_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an
// arithmetic reference model (WIDTH = 32).
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cmp;

  int vectors = 0;
  int errs    = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cmp(cmp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the operation definitions
  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic c);
    longint          sx = $signed(x);
    longint          sy = $signed(y);
    longint unsigned ux = x;
    longint unsigned uy = y;
    int              s  = y % 32;
    r = 32'h0;
    c = 1'b0;
    case (o)
      5'd0:  r = x + y;
      5'd1:  r = x - y;
      5'd2:  r = x & y;
      5'd3:  r = x | y;
      5'd4:  r = x ^ y;
      5'd5:  r = 32'(ux * (64'd1 << s));
      5'd6:  r = 32'(ux / (64'd1 << s));
      5'd7:  r = 32'(sx >>> s);
      5'd8:  r = (sx < sy) ? 32'd1 : 32'd0;
      5'd9:  r = (ux < uy) ? 32'd1 : 32'd0;
      5'd10: begin r = x - y; c = (x == y); end
      5'd11: begin r = x - y; c = (x != y); end
      5'd12: begin r = x - y; c = (sx <  sy); end
      5'd13: begin r = x - y; c = (sx >= sy); end
      5'd14: begin r = x - y; c = (ux <  uy); end
      5'd15: begin r = x - y; c = (ux >= uy); end
      5'd16: r = 32'(ux * uy);
      5'd17: r = 32'((sx * sy) >>> 32);
      5'd18: r = 32'((ux * uy) >> 32);
      5'd19: r = (y == 0) ? 32'hFFFF_FFFF :
                 (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? x : 32'(sx / sy);
      5'd20: r = (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
      5'd21: r = (y == 0) ? x :
                 (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'h0 : 32'(sx % sy);
      5'd22: r = (y == 0) ? x : 32'(ux % uy);
      default: ;
    endcase
  endfunction

  // Issue one op, check latency, result, hold behaviour and return to idle
  task automatic run(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int hold, input string tag);
    logic [31:0] er;
    logic        ec;
    int          lat, cyc;
    model(o, x, y, er, ec);
    lat = (o >= 5'd16 && o <= 5'd22) ? 33 : 1;
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check({tag, " ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    cyc = 1;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " cmp"}, 64'(cmp), 64'(ec));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, er});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " idle"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    logic [31:0] rx, ry;
    logic [4:0]  ro;
    int          cyc;
    logic        seen;
    rst = 1'b1; in_valid = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {60'd0, out_valid, in_ready, cmp, 1'b0} | 64'(result) << 4,
          {60'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0; in_valid = 1'b0;

    run(5'd0,  32'hFFFF_FFFF, 32'd1, 0, "add wrap");
    run(5'd14, 32'd1, 32'hFFFF_FFFF, 0, "bltu");
    run(5'd12, 32'd1, 32'hFFFF_FFFF, 1, "blt");
    run(5'd17, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
    run(5'd16, 32'h8000_0000, 32'h8000_0000, 0, "mul");
    run(5'd19, 32'd7, 32'd0, 0, "div by 0");
    run(5'd21, 32'hFFFF_FFF9, 32'd2, 0, "rem neg");
    run(5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div ovf");
    run(5'd21, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem ovf");
    run(5'd22, 32'd12345, 32'd0, 0, "remu by 0");
    run(5'd7,  32'h8000_0000, 32'h24, 5, "sra hold");
    run(5'd25, 32'h1234_5678, 32'h9, 0, "illegal");

    // Reset in the middle of a divide; in_valid during reset must be ignored
    in_valid = 1'b1; op = 5'd20; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; op = 5'd0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("mid-calc reset", {30'd0, out_valid, in_ready, cmp, result},
          {30'd0, 1'b0, 1'b1, 1'b0, 32'd0});
    seen = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("discarded op", 64'(seen), 64'd0);
    run(5'd0, 32'd2, 32'd3, 0, "add after rst");

    // Randomized ops, biased toward corner operands
    for (int n = 0; n < 60; n++) begin
      ro = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0: rx = 32'h8000_0000;
        1: rx = 32'hFFFF_FFFF;
        2: rx = 32'($urandom_range(0, 20));
        default: rx = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: ry = 32'h0;
        1: ry = 32'hFFFF_FFFF;
        2: ry = 32'($urandom_range(0, 40));
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ry = rx;
      run(ro, rx, ry, $urandom_range(0, 2), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
